// File: rtl/data_memory.sv
`default_nettype none
//=============================================================================
// Module      : data_memory
// Description : Byte-addressable little-endian data memory for the RV32
//               single-cycle datapath. Supports lb/lh/lw/lbu/lhu/sb/sh/sw
//               selected by the instruction funct3 on DMCtrl. Writes are
//               synchronous to the rising clock edge; reads are
//               combinational. An asynchronous reset clears the whole array.
//
// Ports       : Clk      in   clock, writes on rising edge
//               Reset    in   asynchronous active-high reset, clears memory
//               Address  in   byte address, only low AW bits used (wraps)
//               DataWr   in   store data (byte / half / word by DMCtrl)
//               DMCtrl   in   access type (funct3)
//               DMWr     in   1 = store, 0 = load
//               DataRd   out  load data, combinational
//               MisAlign out  access misaligned for its size, combinational
//
// Revision    : 1.0  initial release
//=============================================================================
module data_memory #(
   parameter int DEPTH = 1024,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic [31:0] Address,
   input  logic [31:0] DataWr,
   input  logic [2:0]  DMCtrl,
   input  logic        DMWr,
   output logic [31:0] DataRd,
   output logic        MisAlign
);

   // funct3 encodings of the supported access types
   localparam logic [2:0] C_LB  = 3'b000;
   localparam logic [2:0] C_LH  = 3'b001;
   localparam logic [2:0] C_LW  = 3'b010;
   localparam logic [2:0] C_LBU = 3'b100;
   localparam logic [2:0] C_LHU = 3'b101;

   localparam logic [AW-1:0] C_ONE   = {{(AW-1){1'b0}}, 1'b1};
   localparam logic [AW-1:0] C_TWO   = {{(AW-2){1'b0}}, 2'b10};
   localparam logic [AW-1:0] C_THREE = {{(AW-2){1'b0}}, 2'b11};

   logic [7:0]    mem_q [DEPTH];
   logic [7:0]    mem_d [DEPTH];

   logic [AW-1:0] addr0;
   logic [AW-1:0] addr1;
   logic [AW-1:0] addr2;
   logic [AW-1:0] addr3;
   logic [7:0]    byte0;
   logic [7:0]    byte1;
   logic [7:0]    byte2;
   logic [7:0]    byte3;
   logic          misalign;
   logic          wr_en;
   logic [31:0]   rd_data;

   // Upper address bits only select aliases of the same storage.
   logic          unused_addr;
   assign unused_addr = ^Address[31:AW];

   // Byte lanes; the increments wrap inside the AW-bit index space.
   assign addr0 = Address[AW-1:0];
   assign addr1 = addr0 + C_ONE;
   assign addr2 = addr0 + C_TWO;
   assign addr3 = addr0 + C_THREE;

   assign byte0 = mem_q[addr0];
   assign byte1 = mem_q[addr1];
   assign byte2 = mem_q[addr2];
   assign byte3 = mem_q[addr3];

   // Alignment check depends only on size, never on direction.
   always_comb begin
      misalign = 1'b0;
      case (DMCtrl)
         C_LH, C_LHU: misalign = addr0[0];
         C_LW:        misalign = (addr0[1:0] != 2'b00);
         default:     misalign = 1'b0;
      endcase
   end

   // Reserved codes never write; misaligned stores are dropped.
   always_comb begin
      wr_en = 1'b0;
      case (DMCtrl)
         C_LB, C_LH, C_LW, C_LBU, C_LHU: wr_en = DMWr && !misalign;
         default:                         wr_en = 1'b0;
      endcase
   end

   always_comb begin
      mem_d = mem_q;
      if (wr_en) begin
         case (DMCtrl)
            C_LB, C_LBU: begin
               mem_d[addr0] = DataWr[7:0];
            end
            C_LH, C_LHU: begin
               mem_d[addr0] = DataWr[7:0];
               mem_d[addr1] = DataWr[15:8];
            end
            C_LW: begin
               mem_d[addr0] = DataWr[7:0];
               mem_d[addr1] = DataWr[15:8];
               mem_d[addr2] = DataWr[23:16];
               mem_d[addr3] = DataWr[31:24];
            end
            default: begin
               mem_d[addr0] = mem_q[addr0];
            end
         endcase
      end
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= 8'h00;
         end
      end else begin
         mem_q <= mem_d;
      end
   end

   always_comb begin
      rd_data = 32'h0000_0000;
      case (DMCtrl)
         C_LB:    rd_data = {{24{byte0[7]}}, byte0};
         C_LBU:   rd_data = {24'h000000, byte0};
         C_LH:    rd_data = {{16{byte1[7]}}, byte1, byte0};
         C_LHU:   rd_data = {16'h0000, byte1, byte0};
         C_LW:    rd_data = {byte3, byte2, byte1, byte0};
         default: rd_data = 32'h0000_0000;
      endcase
      // The array is already zero under reset; gating here also hides any
      // lane whose clear has not yet propagated in the same delta.
      if (Reset || misalign) begin
         rd_data = 32'h0000_0000;
      end
   end

   assign DataRd   = rd_data;
   assign MisAlign = misalign;

endmodule
`default_nettype wire

// File: tb/tb_data_memory.sv
`default_nettype none
//=============================================================================
// Module      : tb_data_memory
// Description : Self-checking bench for data_memory. A table of directed
//               {inputs, expected outputs} records is applied one per clock;
//               outputs are sampled 1 time unit after the falling edge, i.e.
//               before that vector's store takes effect. Hand-written
//               sequences cover write-through-edge visibility, asynchronous
//               reset and writes attempted while reset is held.
//
// Revision    : 1.0  initial release
//=============================================================================
module tb_data_memory;

   logic        Clk;
   logic        Reset;
   logic [31:0] Address;
   logic [31:0] DataWr;
   logic [2:0]  DMCtrl;
   logic        DMWr;
   logic [31:0] DataRd;
   logic        MisAlign;

   int n_vec;
   int n_bad;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [2:0]  ctrl;
      logic        wr;
      logic [31:0] exp_data;
      logic        exp_mis;
   } vec_t;

   vec_t vecs[$];

   data_memory #(.DEPTH(1024)) dut (
      .Clk      (Clk),
      .Reset    (Reset),
      .Address  (Address),
      .DataWr   (DataWr),
      .DMCtrl   (DMCtrl),
      .DMWr     (DMWr),
      .DataRd   (DataRd),
      .MisAlign (MisAlign)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic add(input logic [31:0] a, input logic [31:0] wd, input logic [2:0] c,
                      input logic w, input logic [31:0] ed, input logic em);
      vec_t v;
      v.addr = a; v.wdata = wd; v.ctrl = c; v.wr = w; v.exp_data = ed; v.exp_mis = em;
      vecs.push_back(v);
   endtask

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic check1(input string name, input logic act, input logic exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic drive(input logic [31:0] a, input logic [31:0] wd,
                        input logic [2:0] c, input logic w);
      Address = a; DataWr = wd; DMCtrl = c; DMWr = w;
   endtask

   initial begin
      n_vec = 0;
      n_bad = 0;
      Reset = 1'b0;
      drive(32'h0, 32'h0, 3'b010, 1'b0);

      //            addr          wdata         ctrl    wr    exp_data      mis
      add(32'h0000_0000, 32'h1234_5678, 3'b010, 1'b1, 32'h0000_0000, 1'b0); // sw, old=0
      add(32'h0000_0000, 32'h0,         3'b010, 1'b0, 32'h1234_5678, 1'b0); // lw
      add(32'h0000_0004, 32'h8765_4321, 3'b010, 1'b1, 32'h0000_0000, 1'b0); // sw
      add(32'h0000_0000, 32'h0,         3'b010, 1'b0, 32'h1234_5678, 1'b0);
      add(32'h0000_0004, 32'h0,         3'b010, 1'b0, 32'h8765_4321, 1'b0);
      add(32'h0000_0004, 32'h0,         3'b000, 1'b0, 32'h0000_0021, 1'b0); // lb
      add(32'h0000_0007, 32'h0,         3'b000, 1'b0, 32'hFFFF_FF87, 1'b0); // lb neg
      add(32'h0000_0007, 32'h0,         3'b100, 1'b0, 32'h0000_0087, 1'b0); // lbu
      add(32'h0000_0006, 32'h0,         3'b001, 1'b0, 32'hFFFF_8765, 1'b0); // lh neg
      add(32'h0000_0006, 32'h0,         3'b101, 1'b0, 32'h0000_8765, 1'b0); // lhu
      add(32'h0000_0001, 32'hFFFF_FFAB, 3'b000, 1'b1, 32'h0000_0056, 1'b0); // sb, old lb=0x56
      add(32'h0000_0002, 32'hFFFF_CDEF, 3'b001, 1'b1, 32'h0000_1234, 1'b0); // sh, old lh=0x1234
      add(32'h0000_0000, 32'h0,         3'b010, 1'b0, 32'hCDEF_AB78, 1'b0);
      add(32'h0000_0002, 32'hFFFF_FFFF, 3'b010, 1'b1, 32'h0000_0000, 1'b1); // misaligned sw
      add(32'h0000_0000, 32'h0,         3'b010, 1'b0, 32'hCDEF_AB78, 1'b0); // unchanged
      add(32'h0000_0003, 32'h0,         3'b001, 1'b0, 32'h0000_0000, 1'b1); // misaligned lh
      add(32'h0000_0001, 32'h0,         3'b101, 1'b0, 32'h0000_0000, 1'b1); // misaligned lhu
      add(32'h0000_0000, 32'hFFFF_FFFF, 3'b011, 1'b1, 32'h0000_0000, 1'b0); // reserved store
      add(32'h0000_0000, 32'h0,         3'b010, 1'b0, 32'hCDEF_AB78, 1'b0); // unchanged
      add(32'h0000_0000, 32'h0,         3'b110, 1'b0, 32'h0000_0000, 1'b0); // reserved read
      add(32'h0000_0001, 32'h0,         3'b111, 1'b0, 32'h0000_0000, 1'b0); // reserved read
      add(32'h0000_0003, 32'h0,         3'b000, 1'b0, 32'hFFFF_FFCD, 1'b0); // byte never misaligned
      add(32'h0000_0400, 32'h0BAD_F00D, 3'b010, 1'b1, 32'hCDEF_AB78, 1'b0); // sw alias of 0
      add(32'h0000_0000, 32'h0,         3'b010, 1'b0, 32'h0BAD_F00D, 1'b0);
      add(32'hFFFF_FC04, 32'h0,         3'b010, 1'b0, 32'h8765_4321, 1'b0); // alias of 4
      add(32'h0000_03FC, 32'hA5A5_5A5A, 3'b010, 1'b1, 32'h0000_0000, 1'b0); // top word
      add(32'h0000_03FC, 32'h0,         3'b010, 1'b0, 32'hA5A5_5A5A, 1'b0);
      add(32'h0000_03FE, 32'h0,         3'b101, 1'b0, 32'h0000_A5A5, 1'b0);

      // Initial reset: output must read zero while Reset is high.
      #2 Reset = 1'b1;
      #1 check32("reset_state_data", DataRd, 32'h0);
      check1("reset_state_mis", MisAlign, 1'b0);
      @(negedge Clk);
      Reset = 1'b0;

      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge Clk);
         drive(vecs[i].addr, vecs[i].wdata, vecs[i].ctrl, vecs[i].wr);
         #1;
         check32($sformatf("vec%0d_data", i), DataRd, vecs[i].exp_data);
         check1($sformatf("vec%0d_mis", i), MisAlign, vecs[i].exp_mis);
      end

      // Store held across an edge: old data before, new data after, DMWr still 1.
      @(negedge Clk);
      drive(32'h0000_0008, 32'h1122_3344, 3'b010, 1'b1);
      #1 check32("wr_before_edge", DataRd, 32'h0);
      @(posedge Clk);
      #1 check32("wr_after_edge", DataRd, 32'h1122_3344);

      // Asynchronous reset between edges.
      @(negedge Clk);
      drive(32'h0000_0004, 32'h0, 3'b010, 1'b0);
      #1 check32("pre_reset_lw4", DataRd, 32'h8765_4321);
      #1 Reset = 1'b1;
      #1 check32("async_reset_lw4", DataRd, 32'h0);
      #1 Reset = 1'b0;
      #1 check32("cleared_after_release", DataRd, 32'h0);
      drive(32'h0000_0008, 32'h0, 3'b010, 1'b0);
      #0 check32("cleared_word8", DataRd, 32'h0);

      // Write attempted while Reset is held high across an edge.
      @(negedge Clk);
      Reset = 1'b1;
      drive(32'h0000_0000, 32'hDEAD_BEEF, 3'b010, 1'b1);
      @(posedge Clk);
      #1 check32("read_during_reset", DataRd, 32'h0);
      @(negedge Clk);
      Reset = 1'b0;
      drive(32'h0000_0000, 32'h0, 3'b010, 1'b0);
      #1 check32("write_during_reset_ignored", DataRd, 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/data_memory.md
Name: data_memory

Overview:
- Byte-addressable data memory for the RV32 single-cycle datapath; sits after the ALU and is addressed by the ALU result.
- Supports RV32I loads and stores (lb/lh/lw/lbu/lhu, sb/sh/sw), selected by DMCtrl, which carries the instruction funct3.
- Little-endian storage.
- Synchronous write, combinational read.

Parameters:
- DEPTH, 1024, memory size in bytes; must be a power of two and at least 4.
- AW, $clog2(DEPTH), number of address bits used for indexing.

Ports:
- Clk  input  1  clock; all writes occur on the rising edge.
- Reset  input  1  asynchronous, active-high reset; clears the whole memory array.
- Address  input  32  byte address. Only Address[AW-1:0] is used; upper bits are ignored (address wraps modulo DEPTH).
- DataWr  input  32  store data. The low byte, low half or full word is used depending on DMCtrl.
- DMCtrl  input  3  access type: 000 byte signed, 001 half signed, 010 word, 100 byte unsigned, 101 half unsigned; 011, 110 and 111 are reserved.
- DMWr  input  1  write enable (1 = store, 0 = load).
- DataRd  output  32  load data, combinational.
- MisAlign  output  1  combinational flag; high when the current access is misaligned for its size.

Behaviour:
- Storage: DEPTH x 8-bit array. Little-endian: byte k of a word lives at Address+k.
- Reset:
  - Reset=1 clears every byte to 0x00 immediately, without waiting for a clock edge.
  - While Reset is high, writes are ignored and DataRd=0x00000000.
  - Reset has priority over a simultaneous write edge.
- Write (rising Clk, DMWr=1, Reset=0, MisAlign=0):
  - 000 or 100: mem[A] <= DataWr[7:0].
  - 001 or 101: mem[A] <= DataWr[7:0]; mem[A+1] <= DataWr[15:8].
  - 010: mem[A..A+3] <= DataWr[7:0], [15:8], [23:16], [31:24].
  - Reserved codes: no write.
- Misalignment:
  - MisAlign=1 for a halfword access with A[0]=1, or a word access with A[1:0]!=00. Byte accesses are never misaligned.
  - A misaligned write is suppressed; memory is unchanged.
  - A misaligned read returns 0x00000000.
  - MisAlign is driven regardless of DMWr.
- Read (combinational, DataRd always reflects current Address/DMCtrl and memory contents, independent of DMWr):
  - 000: sign-extended mem[A].
  - 100: zero-extended mem[A].
  - 001: sign-extended {mem[A+1], mem[A]}.
  - 101: zero-extended {mem[A+1], mem[A]}.
  - 010: {mem[A+3], mem[A+2], mem[A+1], mem[A]}.
  - Reserved codes: 0x00000000.
- Latency: a write at edge N is visible on DataRd immediately after edge N (same address). While DMWr=1, DataRd shows the old contents until the edge, then the new contents.
- Wrap: only the AW low bits index memory; e.g. with DEPTH=1024, Address 0x00000400 aliases 0x00000000. Aligned accesses never straddle the top of memory.
- Simultaneous events: a write and a read of the same address in the same cycle returns the old data before the edge and the new data after it.

Test Plan:
- Word store/load: Reset pulse; A=0x0, DataWr=0x12345678, DMCtrl=010, DMWr=1, one edge; then DMWr=0 -> DataRd=0x12345678.
- Second word: sw 0x87654321 at A=0x4; read A=0x0 -> 0x12345678; read A=0x4 -> 0x87654321.
- Sub-word loads on word 0x87654321 at A=0x4:
  - lb A=0x4 -> 0x00000021; lb A=0x7 -> 0xFFFFFF87; lbu A=0x7 -> 0x00000087.
  - lh A=0x6 -> 0xFFFF8765; lhu A=0x6 -> 0x00008765.
- Sub-word stores: sb 0xAB at A=0x1, then sh 0xCDEF at A=0x2, both over 0x12345678 at A=0x0 -> lw A=0x0 returns 0xCDEFAB78.
- Misaligned and reserved:
  - sw 0xFFFFFFFF at A=0x2 -> MisAlign=1, memory unchanged (lw A=0x0 still 0xCDEFAB78).
  - lh A=0x3 -> DataRd=0, MisAlign=1.
  - DMCtrl=011 with DMWr=1 -> no write, DataRd=0.
- Async reset and wrap:
  - Assert Reset between clock edges -> lw A=0x4 returns 0 at once.
  - Write with Reset held high -> ignored.
  - sw 0x0BADF00D at A=0x400 -> lw A=0x0 returns 0x0BADF00D.
